// File: rtl/sdram_port_arbiter.sv
// Two-client round-robin arbiter for a single SDRAM master port.
// One access in flight; read/write strobes are single-cycle and latencies are fixed.
module sdram_port_arbiter #(
  parameter int unsigned W         = 16,
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [W-1:0]      wdata0,
  input  logic [W-1:0]      wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [W-1:0]      rdata0,
  output logic [W-1:0]      rdata1,
  output logic              busy,
  output logic              read,
  output logic [ADDR_W-1:0] readaddress,
  input  logic [W-1:0]      readdata,
  output logic              write,
  output logic [ADDR_W-1:0] writeaddress,
  output logic [W-1:0]      writedata
);

  localparam int unsigned MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [W-1:0]        wdata_q, wdata_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic [W-1:0]        rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                read_q, read_d, write_q, write_d;

  logic                pick;
  logic                pick_we;

  // Tie goes to the client that did not own the previous access.
  assign pick    = (req0 && req1) ? ~last_q : req1;
  assign pick_we = pick ? we1 : we0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    read_d   = 1'b0;
    write_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = pick;
          last_d  = pick;
          addr_d  = pick ? addr1 : addr0;
          cnt_d   = CNT_W'(1);
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          if (pick_we) begin
            wdata_d = pick ? wdata1 : wdata0;
            write_d = 1'b1;
            state_d = WR_WAIT;
          end else begin
            read_d  = 1'b1;
            state_d = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        if (cnt_q == CNT_W'(READ_LAT)) begin
          state_d = IDLE;
          if (owner_q) begin
            rdata1_d = readdata;
            done1_d  = 1'b1;
          end else begin
            rdata0_d = readdata;
            done0_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WR_WAIT: begin
        if (cnt_q == CNT_W'(WRITE_LAT)) begin
          state_d = IDLE;
          done0_d = ~owner_q;
          done1_d = owner_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      read_q   <= read_d;
      write_q  <= write_d;
    end
  end

  // The latched address feeds both SDRAM address buses; only the strobe selects the direction.
  assign gnt0         = gnt0_q;
  assign gnt1         = gnt1_q;
  assign done0        = done0_q;
  assign done1        = done1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign busy         = (state_q != IDLE);
  assign read         = read_q;
  assign readaddress  = addr_q;
  assign write        = write_q;
  assign writeaddress = addr_q;
  assign writedata    = wdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized scoreboard bench for sdram_port_arbiter with a behavioural SDRAM and memory model.
module tb_sdram_port_arbiter;

  localparam int unsigned W         = 16;
  localparam int unsigned ADDR_W    = 25;
  localparam int unsigned READ_LAT  = 2;
  localparam int unsigned WRITE_LAT = 10;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [W-1:0]      wdata;
  } req_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_s [2];
  logic              we_s  [2];
  logic [ADDR_W-1:0] addr_s[2];
  logic [W-1:0]      wdata_s[2];
  logic              gnt0, gnt1, done0, done1, busy, read, write;
  logic [W-1:0]      rdata0, rdata1, readdata, writedata;
  logic [ADDR_W-1:0] readaddress, writeaddress;

  sdram_port_arbiter #(
    .W(W), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req_s[0]), .req1(req_s[1]), .we0(we_s[0]), .we1(we_s[1]),
    .addr0(addr_s[0]), .addr1(addr_s[1]), .wdata0(wdata_s[0]), .wdata1(wdata_s[1]),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .read(read), .readaddress(readaddress), .readdata(readdata),
    .write(write), .writeaddress(writeaddress), .writedata(writedata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SDRAM device: read data appears the cycle after the strobe and is held.
  logic [W-1:0] dev_mem[1024];
  logic [W-1:0] ref_mem[1024];
  logic [W-1:0] rd_q = '0;
  assign readdata = rd_q;

  initial forever begin
    @(posedge clk);
    if (read)  rd_q <= dev_mem[readaddress[9:0]];
    if (write) dev_mem[writeaddress[9:0]] = writedata;
  end

  req_t stim[2][$];
  req_t pend[2][$];
  int   grant_log[$];
  int   strobe_log[$];
  int   issued_cnt = 0, gnt_cnt = 0, done_cnt = 0, abort_cnt = 0;

  function automatic req_t mk(input logic we, input int unsigned addr, input logic [W-1:0] wd);
    req_t r;
    r.we    = we;
    r.addr  = ADDR_W'(addr);
    r.wdata = wd;
    return r;
  endfunction

  function automatic int lat_of(input logic we);
    return we ? int'(WRITE_LAT) : int'(READ_LAT);
  endfunction

  // Monitor: grants pop the client's pending queue, dones are checked against the memory model.
  int     cyc = 0, fl_c = 0, fl_start = 0, last_g = 1, mg = 0;
  bit     in_fl = 0, prev_strobe = 0, both_prev = 0;
  req_t   fl_r, mr;
  logic [W-1:0] exp_rd[2];

  initial forever begin
    @(negedge clk);
    if (rst !== 1'b1) begin
      if (in_fl) begin
        abort_cnt++;
        if (fl_r.we) ref_mem[fl_r.addr[9:0]] = fl_r.wdata;
      end
      in_fl = 0; prev_strobe = 0; both_prev = 0; last_g = 1;
      exp_rd[0] = '0; exp_rd[1] = '0;
    end else begin
      cyc++;
      if (done0 || done1) begin
        chk("done_owner", {30'd0, done1, done0}, in_fl ? (fl_c == 1 ? 32'd2 : 32'd1) : 32'd0);
        if (in_fl) begin
          chk("done_latency", cyc - fl_start, lat_of(fl_r.we));
          if (fl_r.we) begin
            ref_mem[fl_r.addr[9:0]] = fl_r.wdata;
            chk("done_wr_addr", writeaddress, fl_r.addr);
            chk("done_wr_data", writedata, fl_r.wdata);
          end else begin
            exp_rd[fl_c] = ref_mem[fl_r.addr[9:0]];
          end
          chk("rdata0", rdata0, exp_rd[0]);
          chk("rdata1", rdata1, exp_rd[1]);
          chk("busy_in_done", busy, 0);
          in_fl = 0;
          done_cnt++;
        end
      end else if (in_fl) begin
        chk("busy_wait", busy, 1);
        if (fl_r.we) begin
          chk("wr_addr_held", writeaddress, fl_r.addr);
          chk("wr_data_held", writedata, fl_r.wdata);
        end else begin
          chk("rd_addr_held", readaddress, fl_r.addr);
        end
        if (cyc - fl_start >= lat_of(fl_r.we)) begin
          chk("done_missing", done0 | done1, 1);
          in_fl = 0;
        end
      end
      if (read || write) begin
        chk("strobe_excl", read && write, 0);
        chk("strobe_gap", prev_strobe, 0);
        chk("gnt_with_strobe", gnt0 ^ gnt1, 1);
        chk("overlap", in_fl, 0);
        mg = gnt1 ? 1 : 0;
        if (both_prev) chk("rr_order", mg, 1 - last_g);
        if (pend[mg].size() == 0) begin
          chk("gnt_unrequested", pend[mg].size(), 1);
        end else begin
          mr = pend[mg].pop_front();
          chk("strobe_type", write, mr.we);
          chk("strobe_addr", write ? writeaddress : readaddress, mr.addr);
          if (mr.we) chk("strobe_wdata", writedata, mr.wdata);
          in_fl = 1; fl_c = mg; fl_r = mr; fl_start = cyc;
        end
        last_g = mg;
        gnt_cnt++;
        grant_log.push_back(mg);
        strobe_log.push_back(cyc);
      end else begin
        chk("gnt_without_strobe", gnt0 | gnt1, 0);
      end
      prev_strobe = read || write;
      both_prev   = req_s[0] && req_s[1];
    end
  end

  task automatic drive_client(input int c, input int gap_max);
    req_t r;
    int   t;
    while (stim[c].size() > 0) begin
      r = stim[c].pop_front();
      pend[c].push_back(r);
      issued_cnt++;
      req_s[c] = 1'b1; we_s[c] = r.we; addr_s[c] = r.addr; wdata_s[c] = r.wdata;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!(c == 0 ? gnt0 : gnt1) && t < 400);
      chk($sformatf("gnt_wait_c%0d", c), c == 0 ? gnt0 : gnt1, 1);
      @(posedge clk); #1;
      if (stim[c].size() == 0 || gap_max > 0) req_s[c] = 1'b0;
      if (gap_max > 0) begin
        t = $urandom_range(gap_max, 0);
        if (t > 0) begin
          repeat (t) @(posedge clk);
          #1;
        end
      end
    end
    req_s[c] = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((stim[0].size() != 0 || stim[1].size() != 0 || pend[0].size() != 0 ||
            pend[1].size() != 0 || in_fl || req_s[0] || req_s[1]) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_reached", t < 3000, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"},   {gnt0, gnt1}, 0);
    chk({tag, "_done"},  {done0, done1}, 0);
    chk({tag, "_strb"},  {read, write, busy}, 0);
    chk({tag, "_raddr"}, readaddress, 0);
    chk({tag, "_waddr"}, writeaddress, 0);
    chk({tag, "_wdata"}, writedata, 0);
    chk({tag, "_rdata"}, {rdata1, rdata0}, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b0;
    #1 check_zero("rst");
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      req_s[c] = 1'b0; we_s[c] = 1'b0; addr_s[c] = '0; wdata_s[c] = '0;
    end
    for (int i = 0; i < 1024; i++) begin
      dev_mem[i] = W'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    #12 check_zero("init");
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;

    // Single read by the engine.
    dev_mem[16] = 16'h00AB; ref_mem[16] = 16'h00AB;
    stim[1].push_back(mk(1'b0, 16, '0));
    drive_client(1, 0);
    wait_idle();
    chk("t1_rdata1", rdata1, 16'h00AB);

    // Single write by the loader, idle afterwards.
    stim[0].push_back(mk(1'b1, 960, 16'h0005));
    drive_client(0, 0);
    wait_idle();
    chk("t2_busy_after", busy, 0);
    chk("t2_mem", dev_mem[960], 16'h0005);

    // Contention straight after reset, then both held.
    do_reset();
    grant_log.delete(); strobe_log.delete();
    stim[0].push_back(mk(1'b1, 100, 16'h1234));
    stim[1].push_back(mk(1'b0, 100, '0));
    fork
      drive_client(0, 0);
      drive_client(1, 0);
    join
    wait_idle();
    chk("t3_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t3_first", grant_log[0], 0);
      chk("t3_second", grant_log[1], 1);
      chk("t3_spacing", strobe_log[1] - strobe_log[0], WRITE_LAT + 1);
    end
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      stim[0].push_back(mk(1'($urandom), $urandom_range(63, 0), W'($urandom)));
      stim[1].push_back(mk(1'($urandom), $urandom_range(63, 0), W'($urandom)));
    end
    fork
      drive_client(0, 0);
      drive_client(1, 0);
    join
    wait_idle();
    chk("t3_alt_count", grant_log.size(), 8);
    foreach (grant_log[i]) chk("t3_alternate", grant_log[i], i % 2);

    // Engine back-to-back reads.
    strobe_log.delete();
    for (int i = 0; i < 8; i++) stim[1].push_back(mk(1'b0, $urandom_range(1023, 0), '0));
    drive_client(1, 0);
    wait_idle();
    chk("t4_count", strobe_log.size(), 8);
    for (int i = 1; i < strobe_log.size(); i++)
      chk("t4_spacing", strobe_log[i] - strobe_log[i-1], READ_LAT + 1);

    // Reset four cycles into a write, with an engine read queued behind it.
    stim[0].push_back(mk(1'b1, 300, 16'hBEEF));
    stim[1].push_back(mk(1'b0, 300, '0));
    fork
      drive_client(0, 0);
      begin
        int t = 0;
        while (write !== 1'b1 && t < 50) begin
          @(negedge clk);
          t++;
        end
        chk("t5_write_seen", write, 1);
        @(posedge clk); #1;
        fork
          drive_client(1, 0);
        join_none
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1 check_zero("t5");
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
      end
    join
    wait_idle();
    chk("t5_abort", abort_cnt, 1);

    // Loader fills 128 records, engine reads them back.
    for (int i = 0; i < 128; i++) stim[0].push_back(mk(1'b1, 512 + i, W'($urandom)));
    drive_client(0, 0);
    wait_idle();
    for (int i = 0; i < 128; i++) stim[1].push_back(mk(1'b0, 512 + i, '0));
    drive_client(1, 0);
    wait_idle();

    // Mixed random traffic on a small address window.
    for (int i = 0; i < 40; i++) begin
      stim[0].push_back(mk(1'($urandom_range(3, 0) != 0), $urandom_range(31, 0), W'($urandom)));
      stim[1].push_back(mk(1'($urandom_range(3, 0) == 0), $urandom_range(31, 0), W'($urandom)));
    end
    fork
      drive_client(0, 3);
      drive_client(1, 3);
    join
    wait_idle();

    chk("gnt_count", gnt_cnt, issued_cnt);
    chk("done_count", done_cnt, issued_cnt - abort_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
